cu_ex_issue: RTL and testbench

- ID-to-EX issue buffer that produces the 11-bit control field consumed by the EX-stage control decoder.
- Accepts decoded instructions from ID with a valid/ready handshake and holds them in a 2-entry skid FIFO.
- Packs the control field as {funct7[5], funct3, opcode[6:2], br_equal, br_less}.
- Supports pipeline flush; forwards the PC alongside each entry.

---
 rtl/cu_ex_issue.sv | 144 ++++++++++++++
 tb/tb_cu_ex_issue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_ex_issue.sv
// rtl/cu_ex_issue.sv - ID-to-EX issue buffer producing the EX control field
//
// Two-entry skid FIFO between ID and EX. Each entry carries the control
// bits {funct7[5], funct3, opcode[6:2]}, the PC and an illegal flag. The EX
// branch comparator flags are appended combinationally as the low two bits.
//
// Optional feature macro: CU_EX_ILLEGAL_TRAP_EN
//   defined   : unsupported encodings are stored as ADDI (NOP) with illegal=1,
//               o_illegal reports the head entry's flag
//   undefined : raw fields stored, o_illegal tied low, no detection logic
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_valid/o_ready           ID-side handshake, i_instr/i_pc payload
//   i_flush                   synchronous kill of all buffered entries
//   o_valid/i_ready           EX-side handshake on the head entry
//   i_br_equal, i_br_less     EX comparator flags, bits [1:0] of the field
//   o_control_signal          {f7b5, funct3, opc, br_equal, br_less}
//   o_pc, o_illegal           head entry PC and illegal flag

module cu_ex_issue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  input  logic            i_br_equal,
  input  logic            i_br_less,
  output logic [10:0]     o_control_signal,
  output logic [PC_W-1:0] o_pc,
  output logic            o_illegal
);

  typedef struct packed {
    logic            f7b5;
    logic [2:0]      funct3;
    logic [4:0]      opc;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t in_entry;
  logic   push;
  logic   pop;

  // Entry built from the incoming instruction word.
  always_comb begin
    in_entry.f7b5    = i_instr[30];
    in_entry.funct3  = i_instr[14:12];
    in_entry.opc     = i_instr[6:2];
    in_entry.pc      = i_pc;
    in_entry.illegal = 1'b0;
`ifdef CU_EX_ILLEGAL_TRAP_EN
    if (i_instr[1:0] != 2'b11) begin
      in_entry.illegal = 1'b1;
    end else begin
      case (i_instr[6:2])
        5'b00000, 5'b00100, 5'b00101, 5'b01000,
        5'b01100, 5'b11000, 5'b11001, 5'b11011: in_entry.illegal = 1'b0;
        default:                                in_entry.illegal = 1'b1;
      endcase
    end
    // Replace unsupported encodings with ADDI so EX sees a harmless op.
    if (in_entry.illegal) begin
      in_entry.f7b5   = 1'b0;
      in_entry.funct3 = 3'b000;
      in_entry.opc    = 5'b00100;
    end
`endif
  end

  // Handshakes depend only on the state register, so o_ready never
  // combinationally follows i_ready.
  assign o_valid = (state != EMPTY);
  assign o_ready = (state != FULL);
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  // head is always the oldest entry; tail holds the second one when FULL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (i_flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= in_entry;
          end else if (push) begin
            tail  <= in_entry;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign o_control_signal = o_valid ?
      {head.f7b5, head.funct3, head.opc, i_br_equal, i_br_less} : 11'h000;
  assign o_pc = o_valid ? head.pc : '0;

`ifdef CU_EX_ILLEGAL_TRAP_EN
  assign o_illegal = o_valid & head.illegal;
`else
  assign o_illegal = 1'b0;
`endif

  // Instruction bits not part of the control field, and configuration-only
  // signals, are gathered here so they are visibly intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{i_instr[31], i_instr[29:15], i_instr[11:7],
                       i_instr[1:0], head.illegal, (DEPTH == 2)};

endmodule

// File: tb/tb_cu_ex_issue.sv
// tb/tb_cu_ex_issue.sv - directed self-checking bench for cu_ex_issue

module tb_cu_ex_issue;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic        br_equal;
  logic        br_less;
  logic [10:0] ctrl;
  logic [31:0] pc_out;
  logic        illegal;

  int checks_total;
  int checks_passed;

  localparam logic [31:0] ADD_I = 32'h00B50533;
  localparam logic [31:0] SUB_I = 32'h40B50533;
  localparam logic [31:0] AND_I = 32'h00C5F533;
  localparam logic [31:0] BAD_I = 32'h0000007F;
  localparam logic [31:0] LO_I  = 32'h00B50531;

`ifdef CU_EX_ILLEGAL_TRAP_EN
  localparam logic [10:0] BAD_CTRL = 11'h010;
  localparam logic        BAD_ILL  = 1'b1;
  localparam logic [10:0] LO_CTRL  = 11'h010;
`else
  localparam logic [10:0] BAD_CTRL = 11'h07C;
  localparam logic        BAD_ILL  = 1'b0;
  localparam logic [10:0] LO_CTRL  = 11'h030;
`endif

  cu_ex_issue #(.PC_W(32), .DEPTH(2)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_valid          (valid_in),
    .o_ready          (ready_out),
    .i_instr          (instr),
    .i_pc             (pc_in),
    .i_flush          (flush),
    .o_valid          (valid_out),
    .i_ready          (ready_in),
    .i_br_equal       (br_equal),
    .i_br_less        (br_less),
    .o_control_signal (ctrl),
    .o_pc             (pc_out),
    .o_illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    check({tag, "_ctrl"}, {21'd0, ctrl}, 32'd0);
    check({tag, "_pc"}, pc_out, 32'd0);
    check({tag, "_ill"}, {31'd0, illegal}, 32'd0);
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
    valid_in = 1'b1;
    instr    = ins;
    pc_in    = pc;
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    instr    = '0;
    pc_in    = '0;
    flush    = 1'b0;
    ready_in = 1'b0;
    br_equal = 1'b0;
    br_less  = 1'b0;
    repeat (3) tick();
    check_empty("reset");
    rst_n = 1'b1;
    tick();

    // add, single push/pop
    ready_in = 1'b1;
    push_one(ADD_I, 32'h100);
    check("add_valid", {31'd0, valid_out}, 32'd1);
    check("add_ctrl", {21'd0, ctrl}, 32'h030);
    check("add_pc", pc_out, 32'h100);
    tick();
    check_empty("add_pop");

    // sub held, flags passed straight through
    ready_in = 1'b0;
    br_equal = 1'b1;
    push_one(SUB_I, 32'h104);
    check("sub_ctrl", {21'd0, ctrl}, 32'h432);
    br_equal = 1'b0;
    br_less  = 1'b1;
    #1;
    check("sub_ctrl_lt", {21'd0, ctrl}, 32'h431);
    br_equal = 1'b1;
    #1;
    check("sub_ctrl_both", {21'd0, ctrl}, 32'h433);
    br_equal = 1'b0;
    br_less  = 1'b0;
    ready_in = 1'b1;
    tick();
    check("sub_pop_valid", {31'd0, valid_out}, 32'd0);

    // three back-to-back with EX stalled
    ready_in = 1'b0;
    push_one(ADD_I, 32'h0);
    check("bb1_ready", {31'd0, ready_out}, 32'd1);
    push_one(SUB_I, 32'h4);
    check("bb2_ready", {31'd0, ready_out}, 32'd0);
    valid_in = 1'b1;
    instr    = AND_I;
    pc_in    = 32'h8;
    tick();
    check("bb3_held_ready", {31'd0, ready_out}, 32'd0);
    check("bb3_head_pc", pc_out, 32'h0);
    check("bb3_head_ctrl", {21'd0, ctrl}, 32'h030);
    ready_in = 1'b1;
    tick();
    check("bb_pop1_pc", pc_out, 32'h4);
    check("bb_pop1_ctrl", {21'd0, ctrl}, 32'h430);
    check("bb_pop1_ready", {31'd0, ready_out}, 32'd1);
    ready_in = 1'b0;
    tick();
    valid_in = 1'b0;
    check("bb_acc3_ready", {31'd0, ready_out}, 32'd0);
    check("bb_acc3_pc", pc_out, 32'h4);
    ready_in = 1'b1;
    tick();
    check("bb_pop2_pc", pc_out, 32'h8);
    check("bb_pop2_ctrl", {21'd0, ctrl}, 32'h3B0);
    tick();
    check("bb_drain_valid", {31'd0, valid_out}, 32'd0);

    // flush while FULL with a push presented
    ready_in = 1'b0;
    push_one(ADD_I, 32'h10);
    push_one(SUB_I, 32'h14);
    flush    = 1'b1;
    valid_in = 1'b1;
    instr    = AND_I;
    pc_in    = 32'h18;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    check_empty("flush_full");
    tick();
    check("flush_full_stay", {31'd0, valid_out}, 32'd0);

    // flush beats a push in ONE
    push_one(ADD_I, 32'h20);
    flush    = 1'b1;
    valid_in = 1'b1;
    instr    = SUB_I;
    pc_in    = 32'h24;
    ready_in = 1'b1;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    check_empty("flush_one");

    // illegal encodings
    ready_in = 1'b0;
    push_one(BAD_I, 32'h30);
    check("bad_ctrl", {21'd0, ctrl}, {21'd0, BAD_CTRL});
    check("bad_ill", {31'd0, illegal}, {31'd0, BAD_ILL});
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    push_one(LO_I, 32'h34);
    check("lo_ctrl", {21'd0, ctrl}, {21'd0, LO_CTRL});
    check("lo_ill", {31'd0, illegal}, {31'd0, BAD_ILL});
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;

    // asynchronous reset mid-cycle while FULL
    push_one(ADD_I, 32'h40);
    push_one(SUB_I, 32'h44);
    check("prerst_ready", {31'd0, ready_out}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_empty("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, ready_out}, 32'd1);
    check("post_rst_valid", {31'd0, valid_out}, 32'd0);
    push_one(AND_I, 32'h50);
    check("post_rst_pc", pc_out, 32'h50);
    check("post_rst_ctrl", {21'd0, ctrl}, 32'h3B0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
